// File: rtl/pool_seq_if.sv
// Handshake and buffer-port bundle for the 2x2 average-pooling sequencer.
// The master side is the sequencer. The slave side is the buffers and the controller.
interface pool_seq_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 10
);
  logic              start;
  logic              busy;
  logic              done;
  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0] rd_data;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;

  modport master (
    input  start, rd_data,
    output busy, done, rd_en, rd_addr, wr_en, wr_addr, wr_data
  );

  modport slave (
    output start, rd_data,
    input  busy, done, rd_en, rd_addr, wr_en, wr_addr, wr_data
  );
endinterface

// File: rtl/pool_seq.sv
// 2x2 average-pooling sequencer.
// It walks the input map one window at a time: four reads, one drain cycle for the
// last read's data, then one write of floor(sum/4). Each window takes 6 cycles.
// Every output is a flop, loaded from the next-state logic.
module pool_seq #(
  parameter int WIDTH  = 28,
  parameter int HEIGHT = 28,
  parameter int DATA_W = 16,
  parameter int ADDR_W = 10
) (
  input  logic         clk,
  input  logic         rst,
  pool_seq_if.master   bus
);
  localparam int WO = WIDTH / 2;
  localparam int HO = HEIGHT / 2;
  localparam int CW = $clog2(WO + 1);
  localparam int RW = $clog2(HO + 1);

  typedef enum logic [2:0] {IDLE, READ, DRAIN, WRITE, DONE} state_t;

  state_t                    state, state_n;
  logic [1:0]                q, q_n;
  logic [RW-1:0]             r, r_n;
  logic [CW-1:0]             c, c_n;
  logic signed [DATA_W+1:0]  acc, acc_n, sum, shr;

  logic              busy_q, busy_n, done_q, done_n;
  logic              rd_en_q, rd_en_n, wr_en_q, wr_en_n;
  logic [ADDR_W-1:0] rd_addr_q, rd_addr_n, wr_addr_q, wr_addr_n;
  logic [DATA_W-1:0] wr_data_q, wr_data_n;
  logic              last;

  // q selects the pixel within the window: bit1 is the row offset, bit0 the column offset.
  function automatic logic [ADDR_W-1:0] raddr(input logic [RW-1:0] rr,
                                               input logic [CW-1:0] cc,
                                               input logic [1:0]    qq);
    int y, x;
    y = 2 * int'(rr) + int'(qq[1]);
    x = 2 * int'(cc) + int'(qq[0]);
    return ADDR_W'(y * WIDTH + x);
  endfunction

  // Four DATA_W values fit in DATA_W+2 bits, so the shifted sum always fits in DATA_W.
  assign sum  = acc + $signed({{2{bus.rd_data[DATA_W-1]}}, bus.rd_data});
  assign shr  = sum >>> 2;
  assign last = (r == RW'(HO - 1)) && (c == CW'(WO - 1));

  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.rd_en   = rd_en_q;
  assign bus.rd_addr = rd_addr_q;
  assign bus.wr_en   = wr_en_q;
  assign bus.wr_addr = wr_addr_q;
  assign bus.wr_data = wr_data_q;

  // Next-state, window walk and next output values. Addresses and data hold by default.
  always_comb begin
    state_n   = state;
    q_n       = q;
    r_n       = r;
    c_n       = c;
    acc_n     = acc;
    busy_n    = 1'b0;
    done_n    = 1'b0;
    rd_en_n   = 1'b0;
    wr_en_n   = 1'b0;
    rd_addr_n = rd_addr_q;
    wr_addr_n = wr_addr_q;
    wr_data_n = wr_data_q;

    // Read data lags rd_en by one cycle, so the adds run from q=1 through DRAIN.
    if (state == READ && q == 2'd0)        acc_n = '0;
    else if (state == READ || state == DRAIN) acc_n = sum;

    case (state)
      IDLE: begin
        if (bus.start) begin
          state_n   = READ;
          q_n       = 2'd0;
          r_n       = '0;
          c_n       = '0;
          busy_n    = 1'b1;
          rd_en_n   = 1'b1;
          rd_addr_n = '0;
        end
      end
      READ: begin
        busy_n = 1'b1;
        if (q == 2'd3) begin
          state_n = DRAIN;
        end else begin
          q_n       = q + 2'd1;
          rd_en_n   = 1'b1;
          rd_addr_n = raddr(r, c, q_n);
        end
      end
      DRAIN: begin
        busy_n    = 1'b1;
        state_n   = WRITE;
        wr_en_n   = 1'b1;
        wr_addr_n = ADDR_W'(int'(r) * WO + int'(c));
        wr_data_n = shr[DATA_W-1:0];
      end
      WRITE: begin
        if (last) begin
          state_n = DONE;
          done_n  = 1'b1;
        end else begin
          busy_n  = 1'b1;
          state_n = READ;
          q_n     = 2'd0;
          if (c == CW'(WO - 1)) begin
            c_n = '0;
            r_n = r + 1'b1;
          end else begin
            c_n = c + 1'b1;
          end
          rd_en_n   = 1'b1;
          rd_addr_n = raddr(r_n, c_n, 2'd0);
        end
      end
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // State, counters, accumulator and registered outputs. Reset clears all of them.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      q         <= '0;
      r         <= '0;
      c         <= '0;
      acc       <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      rd_en_q   <= 1'b0;
      wr_en_q   <= 1'b0;
      rd_addr_q <= '0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
    end else begin
      state     <= state_n;
      q         <= q_n;
      r         <= r_n;
      c         <= c_n;
      acc       <= acc_n;
      busy_q    <= busy_n;
      done_q    <= done_n;
      rd_en_q   <= rd_en_n;
      wr_en_q   <= wr_en_n;
      rd_addr_q <= rd_addr_n;
      wr_addr_q <= wr_addr_n;
      wr_data_q <= wr_data_n;
    end
  end
endmodule

// File: doc/pool_seq.md
# pool_seq

Sequencer for 2x2 average pooling over a feature map held in a single-port buffer. On `start` it walks the HEIGHT x WIDTH input map window by window, issues the four reads of each 2x2 window, sums them, and writes the average to an output buffer of (HEIGHT/2) x (WIDTH/2). It is the time-multiplexed, memory-backed counterpart of the fully parallel pooling stage. It sits between the conv-output buffer and the next layer's input buffer.

## Interface
- `WIDTH`, 28: input map width in pixels; must be even and >= 2.
- `HEIGHT`, 28: input map height in pixels; must be even and >= 2.
- `DATA_W`, 16: pixel width; signed two's complement.
- `ADDR_W`, 10: address width for both buffers; must satisfy 2^ADDR_W >= WIDTH*HEIGHT.

Ports:
- `clk` in 1: single clock; all logic is rising-edge.
- `rst` in 1: asynchronous, active-high reset.
- `start` in 1: begin one pooling pass; sampled only in IDLE.
- `busy` out 1: pass in progress.
- `done` out 1: one-cycle pulse after the final write.
- `rd_en` out 1: input-buffer read strobe.
- `rd_addr` out ADDR_W: input read address, row-major (y*WIDTH + x).
- `rd_data` in DATA_W: read data, valid exactly 1 cycle after `rd_en`.
- `wr_en` out 1: output-buffer write strobe.
- `wr_addr` out ADDR_W: output address, row-major (r*(WIDTH/2) + c).
- `wr_data` out DATA_W: averaged pixel.

## Operation
- States: IDLE, READ, DRAIN, WRITE, DONE.
- IDLE: when `start`=1, go to READ. Window (r,c)=(0,0), q=0.
- READ: lasts 4 cycles (q=0..3) with `rd_en`=1 on each cycle. Read order for window (r,c):
  - (2r, 2c)
  - (2r, 2c+1)
  - (2r+1, 2c)
  - (2r+1, 2c+1)
- Then go to DRAIN for 1 cycle, then WRITE.
- Accumulator: signed, DATA_W+2 bits. It is cleared at READ q=0 and adds `rd_data` on READ q=1..3 and in DRAIN. After DRAIN it holds exactly the 4-pixel sum.
- WRITE: 1 cycle with `wr_en`=1, `wr_addr`=r*(WIDTH/2)+c, `wr_data` = sum arithmetically shifted right by 2 (floor), truncated to DATA_W. This result cannot overflow.
- Window advance after WRITE: c increments. When c wraps from WIDTH/2-1 to 0, r increments. After the last window (r=HEIGHT/2-1, c=WIDTH/2-1), go to DONE; otherwise go to READ.
- DONE: 1 cycle with `done`=1, then IDLE.
- `start` is ignored outside IDLE; no queuing.
- `rd_en` and `wr_en` are never high in the same cycle.
- Outputs in IDLE and DONE: `rd_en`=`wr_en`=0, and addresses and `wr_data` hold their last values.

## Timing
- Reset values: state IDLE; `busy`, `done`, `rd_en`, `wr_en`, `rd_addr`, `wr_addr`, `wr_data`, accumulator and counters all 0.
- `rst` mid-pass aborts immediately. Outputs take reset values and no further reads or writes occur. A new `start` after reset begins again at window (0,0).
- All outputs are registered and driven from state.
- Cycle numbering, with `start` sampled at edge 0:
  - cycles 1–4: reads of window 0;
  - cycle 5: DRAIN;
  - cycle 6: write of window 0;
  - window n is written at cycle 6+6n.
- Each window takes 6 cycles. A pass takes 6*(WIDTH*HEIGHT/4) cycles plus 1 cycle for DONE. For 28x28: last write at cycle 1176, `done` at cycle 1177.
- `busy`=1 from cycle 1 through the last WRITE cycle, and 0 in DONE and IDLE.
- `start` held high continuously starts a new pass in the cycle after DONE, i.e. the first IDLE cycle samples it.

## Test plan
- 4x4 map, pixels 0..15 row-major, one `start`:
  - writes 2, 4, 10, 12 to addresses 0..3 at cycles 6, 12, 18, 24;
  - `done` at cycle 25;
  - `rd_addr` sequence 0,1,4,5, 2,3,6,7, 8,9,12,13, 10,11,14,15.
- Signed rounding:
  - window -1,-1,-1,-2 (sum -5) -> `wr_data`=-2 (0xFFFE);
  - window 1,1,1,2 -> 1;
  - window 3,0,0,0 -> 0.
- Extremes:
  - all 32767 -> 32767;
  - all -32768 -> -32768;
  - mixed 32767,32767,-32768,-32768 -> -1.
- `start` pulsed at cycles 3 and 10 during a pass -> no effect; `done` still at cycle 25 for 4x4; `start` asserted in DONE -> ignored.
- `rst` asserted at cycle 9 of a 4x4 pass:
  - all outputs 0 immediately, with no write to address 1;
  - a `start` after reset release reproduces the full first-scenario sequence.
- Default 28x28 with random data:
  - 196 writes matching a reference average per window;
  - no cycle with `rd_en` and `wr_en` both high;
  - `done` at cycle 1177.
